// File: rtl/output_activation.sv
// output_activation
//   Output-layer activation stage of the digit recognizer. Converts ten
//   signed neuron sums (one per accepted sum_valid) into 4-bit confidences
//   through a piecewise-linear sigmoid. Buffers them with the one-hot
//   expected label and tracks the running arg-max digit. Once the downstream
//   cost calculator reports calculation_complete, it issues a one-cycle
//   cost_en.
//
// Ports
//   clk                  system clock, rising edge
//   n_rst                asynchronous active-low reset
//   sample_start         begins a sample (accepted only in IDLE)
//   label_in[3:0]        expected digit, sampled with an accepted start
//   sum_valid            sum_in holds the sum for the current digit index
//   sum_in[15:0]         signed neuron sum, FRAC_SHIFT fractional bits
//   calculation_complete cost calculator ready for cost_en
//   cost_en              one-cycle start pulse (decoded from FIRE)
//   expected_label[0:9]  one-hot label, index 0 = digit 0
//   digit_weights[0:9]   4-bit confidence per digit
//   pred_digit[3:0]      arg-max digit (lowest index wins ties)
//   ready                block is in IDLE
//   overrun              one-cycle pulse after a protocol violation
module output_activation #(
  parameter int FRAC_SHIFT = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sample_start,
  input  logic [3:0]       label_in,
  input  logic             sum_valid,
  input  logic [15:0]      sum_in,
  input  logic             calculation_complete,
  output logic             cost_en,
  output logic [0:9]       expected_label,
  output logic [0:9][3:0]  digit_weights,
  output logic [3:0]       pred_digit,
  output logic             ready,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WAIT    = 2'd2,
    ST_FIRE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       best_val_q, best_val_d;
  logic [3:0]       pred_q, pred_d;
  logic [0:9]       label_q, label_d;
  logic [0:9][3:0]  weights_q, weights_d;
  logic             overrun_q, overrun_d;
  logic [3:0]       sig_y;

  // Piecewise-linear sigmoid: y = 8 + (s >>> (FRAC_SHIFT-2)), saturated to
  // [0,15]. One extra bit of headroom keeps the +8 from wrapping.
  function automatic logic [3:0] sigmoid(input logic signed [15:0] s);
    logic signed [16:0] ext;
    logic signed [16:0] y;
    ext = {s[15], s};
    y   = (ext >>> (FRAC_SHIFT - 2)) + 17'sd8;
    if (y < 17'sd0)
      return 4'd0;
    else if (y > 17'sd15)
      return 4'd15;
    else
      return y[3:0];
  endfunction

  assign sig_y = sigmoid(signed'(sum_in));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_val_d = best_val_q;
    pred_d     = pred_q;
    label_d    = label_q;
    weights_d  = weights_q;

    // Offending inputs are flagged but otherwise have no effect.
    overrun_d  = (sum_valid && (state_q != ST_COLLECT)) ||
                 (sample_start && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (sample_start) begin
          // Labels above 9 leave every bit clear.
          for (int i = 0; i < 10; i++)
            label_d[i] = (label_in == 4'(i));
          idx_d      = 4'd0;
          best_val_d = 4'd0;
          pred_d     = 4'd0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (sum_valid) begin
          weights_d[idx_q] = sig_y;
          // Strict compare keeps the lowest index on ties.
          if ((idx_q == 4'd0) || (sig_y > best_val_q)) begin
            best_val_d = sig_y;
            pred_d     = idx_q;
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd9)
            state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (calculation_complete)
          state_d = ST_FIRE;
      end
      ST_FIRE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      best_val_q <= 4'd0;
      pred_q     <= 4'd0;
      label_q    <= '0;
      weights_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_val_q <= best_val_d;
      pred_q     <= pred_d;
      label_q    <= label_d;
      weights_q  <= weights_d;
      overrun_q  <= overrun_d;
    end
  end

  assign cost_en        = (state_q == ST_FIRE);
  assign ready          = (state_q == ST_IDLE);
  assign overrun        = overrun_q;
  assign expected_label = label_q;
  assign digit_weights  = weights_q;
  assign pred_digit     = pred_q;

endmodule
